// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// APB register block. Each rising edge of RxDone captures {~RxStopBit, RxData}
// into a circular FIFO; the oldest entry is presented first-word-fall-through.
//
// Ports:
//   pClk, pReset     clock, asynchronous active-high reset
//   RxDone           frame-complete level; a push occurs on its 0->1 edge
//   RxData, RxStopBit received byte and sampled stop bit (0 = framing error)
//   rd_en            pop request, one pulse per byte (ignored while empty)
//   flush            synchronous clear of contents (overrides push/pop)
//   ovr_clr          clears the sticky overrun flag
//   rd_data, rd_ferr head entry byte and framing-error flag
//   empty, full      occupancy flags
//   level            entry count, 0..DEPTH
//   overrun          sticky: a frame was dropped while full
//   irq_thresh       level >= THRESH
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned THRESH = 8
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              RxDone,
    input  logic [7:0]        RxData,
    input  logic              RxStopBit,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              ovr_clr,
    output logic [7:0]        rd_data,
    output logic              rd_ferr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    output logic              irq_thresh
);

    localparam int unsigned CntW   = ADDR_W + 1;
    localparam int unsigned EntryW = 9;

    logic [EntryW-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [CntW-1:0]   count;
    logic              doneQ;
    logic              overrunQ;

    logic push;
    logic pop;
    logic wrEn;
    logic drop;

    // Edge detect on RxDone; pop only when something is stored
    assign push = RxDone & ~doneQ;
    assign pop  = rd_en & ~empty;

    // A push is accepted when there is room, or when a pop frees a slot this
    // same cycle (full + push + pop writes the slot being vacated).
    assign wrEn = push & ~flush & (~full | pop);
    assign drop = push & ~flush & full & ~pop;

    // Pointer, count, edge-detect and overrun state
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            doneQ    <= 1'b0;
            overrunQ <= 1'b0;
        end else begin
            doneQ <= RxDone;

            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (wrEn) begin
                    wp <= wp + ADDR_W'(1);
                end
                if (pop) begin
                    rp <= rp + ADDR_W'(1);
                end
                if (wrEn && !pop) begin
                    count <= count + CntW'(1);
                end else if (!wrEn && pop) begin
                    count <= count - CntW'(1);
                end
            end

            // Set wins over clear when both happen together
            if (drop) begin
                overrunQ <= 1'b1;
            end else if (ovr_clr) begin
                overrunQ <= 1'b0;
            end
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge pClk) begin
        if (wrEn) begin
            mem[wp] <= {~RxStopBit, RxData};
        end
    end

    // Status and head entry decoded from registers
    assign empty      = (count == CntW'(0));
    assign full       = (count == CntW'(DEPTH));
    assign level      = count;
    assign irq_thresh = (count >= CntW'(THRESH));
    assign overrun    = overrunQ;
    assign {rd_ferr, rd_data} = mem[rp];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;

    logic       pClk;
    logic       pReset;
    logic       RxDone;
    logic [7:0] RxData;
    logic       RxStopBit;
    logic       rd_en;
    logic       flush;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       rd_ferr;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       irq_thresh;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(
        .DEPTH (16),
        .ADDR_W(4),
        .THRESH(8)
    ) dut (
        .pClk      (pClk),
        .pReset    (pReset),
        .RxDone    (RxDone),
        .RxData    (RxData),
        .RxStopBit (RxStopBit),
        .rd_en     (rd_en),
        .flush     (flush),
        .ovr_clr   (ovr_clr),
        .rd_data   (rd_data),
        .rd_ferr   (rd_ferr),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overrun   (overrun),
        .irq_thresh(irq_thresh)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    // One push: RxDone high for one cycle, then low so the next push sees an edge
    task automatic pushByte(input logic [7:0] d, input logic stop);
        RxData    = d;
        RxStopBit = stop;
        RxDone    = 1'b1;
        tick();
        RxDone    = 1'b0;
        tick();
    endtask

    task automatic popByte();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        pReset    = 1'b1;
        RxDone    = 1'b0;
        RxData    = 8'h00;
        RxStopBit = 1'b1;
        rd_en     = 1'b0;
        flush     = 1'b0;
        ovr_clr   = 1'b0;
        tick();
        tick();
        pReset = 1'b0;
        tick();

        // Reset state
        chk("rst_empty",   32'(empty),      32'd1);
        chk("rst_full",    32'(full),       32'd0);
        chk("rst_level",   32'(level),      32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_irq",     32'(irq_thresh), 32'd0);

        // Three frames, then three pops in order
        pushByte(8'h41, 1'b1);
        chk("p1_level", 32'(level), 32'd1);
        chk("p1_empty", 32'(empty), 32'd0);
        pushByte(8'h42, 1'b1);
        chk("p2_level", 32'(level), 32'd2);
        pushByte(8'h43, 1'b1);
        chk("p3_level", 32'(level), 32'd3);
        chk("p3_head",  32'(rd_data), 32'h41);
        chk("p3_ferr",  32'(rd_ferr), 32'd0);
        chk("pop1_data", 32'(rd_data), 32'h41);
        popByte();
        chk("pop2_data", 32'(rd_data), 32'h42);
        popByte();
        chk("pop3_data", 32'(rd_data), 32'h43);
        popByte();
        chk("pop_empty", 32'(empty), 32'd1);
        chk("pop_level", 32'(level), 32'd0);

        // RxDone held high for 20 cycles gives one entry
        RxData    = 8'h55;
        RxStopBit = 1'b1;
        RxDone    = 1'b1;
        repeat (20) tick();
        RxDone = 1'b0;
        tick();
        chk("hold_level", 32'(level),   32'd1);
        chk("hold_data",  32'(rd_data), 32'h55);
        popByte();
        chk("hold_empty", 32'(empty), 32'd1);

        // Framing error
        pushByte(8'hA5, 1'b0);
        chk("ferr_flag", 32'(rd_ferr), 32'd1);
        chk("ferr_data", 32'(rd_data), 32'hA5);
        popByte();
        chk("ferr_empty", 32'(empty), 32'd1);

        // Overflow: 17 pushes into 16 entries
        for (int i = 0; i < 16; i++) begin
            pushByte(8'(i), 1'b1);
        end
        chk("ovf_full",     32'(full),       32'd1);
        chk("ovf_level",    32'(level),      32'd16);
        chk("ovf_pre_ovr",  32'(overrun),    32'd0);
        chk("ovf_irq",      32'(irq_thresh), 32'd1);
        pushByte(8'h10, 1'b1);
        chk("ovf_level17",  32'(level),   32'd16);
        chk("ovf_overrun",  32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(i));
            popByte();
        end
        chk("ovf_drain_empty", 32'(empty),   32'd1);
        chk("ovf_sticky",      32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            pushByte(8'(8'h20 + i), 1'b1);
        end
        chk("fpp_full_pre", 32'(full), 32'd1);
        RxData    = 8'h77;
        RxStopBit = 1'b1;
        RxDone    = 1'b1;
        rd_en     = 1'b1;
        tick();
        RxDone = 1'b0;
        rd_en  = 1'b0;
        tick();
        chk("fpp_level",   32'(level),   32'd16);
        chk("fpp_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fpp_pop%0d", i), 32'(rd_data), 32'(8'h20 + i));
            popByte();
        end
        chk("fpp_pop16", 32'(rd_data), 32'h77);
        popByte();
        chk("fpp_empty", 32'(empty), 32'd1);

        // 40 push+pop cycles at level 1, walking pointers around the array
        pushByte(8'h80, 1'b1);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap_head%0d", i), 32'(rd_data), 32'(8'h80 + i));
            RxData = 8'(8'h81 + i);
            RxDone = 1'b1;
            rd_en  = 1'b1;
            tick();
            RxDone = 1'b0;
            rd_en  = 1'b0;
            tick();
            chk($sformatf("wrap_level%0d", i), 32'(level), 32'd1);
        end
        chk("wrap_last", 32'(rd_data), 32'hA8);
        popByte();
        chk("wrap_empty", 32'(empty), 32'd1);

        // Threshold interrupt
        for (int i = 0; i < 7; i++) begin
            pushByte(8'(8'h60 + i), 1'b1);
        end
        chk("thr_irq7",  32'(irq_thresh), 32'd0);
        pushByte(8'h67, 1'b1);
        chk("thr_level8", 32'(level),      32'd8);
        chk("thr_irq8",   32'(irq_thresh), 32'd1);
        popByte();
        chk("thr_irq_pop", 32'(irq_thresh), 32'd0);
        chk("thr_level7",  32'(level),      32'd7);

        // Flush coincident with push discards everything
        RxData = 8'h99;
        RxDone = 1'b1;
        flush  = 1'b1;
        tick();
        RxDone = 1'b0;
        flush  = 1'b0;
        tick();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);

        // Pop while empty has no effect
        popByte();
        chk("epop_level", 32'(level), 32'd0);
        chk("epop_empty", 32'(empty), 32'd1);
        chk("epop_full",  32'(full),  32'd0);
        pushByte(8'h3C, 1'b1);
        chk("epop_next", 32'(rd_data), 32'h3C);
        chk("epop_lvl1", 32'(level),   32'd1);

        // Asynchronous reset mid-operation clears state before the next edge
        #2;
        pReset = 1'b1;
        #1;
        chk("areset_level", 32'(level), 32'd0);
        chk("areset_empty", 32'(empty), 32'd1);
        tick();
        pReset = 1'b0;
        tick();
        chk("areset_after", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the APB register block. It captures each completed receive frame (data byte plus a stop-bit/framing status) on the rising edge of the receiver's done indication and stores it in a circular FIFO. It presents the oldest entry first-word-fall-through to the register block. It also provides level, full/empty, threshold-interrupt and sticky overrun status, so software need not service every byte in real time.

## Interface

Parameters:
- DEPTH, 16: number of entries; must be a power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH).
- THRESH, 8: level at or above which `irq_thresh` asserts; range 1..DEPTH.

Ports:
- pClk  in  1  system clock; single clock domain.
- pReset  in  1  asynchronous, active-high reset.
- RxDone  in  1  receiver frame-complete indication, level signal; a push occurs on its 0→1 transition.
- RxData  in  8  received byte; valid while RxDone=1.
- RxStopBit  in  1  sampled stop bit; 0 = framing error.
- rd_en  in  1  pop request from the register block, one pulse per byte.
- flush  in  1  synchronous clear of FIFO contents.
- ovr_clr  in  1  clears the sticky overrun flag.
- rd_data  out  8  head entry data; valid when empty=0.
- rd_ferr  out  1  head entry framing error (inverted stored stop bit).
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  ADDR_W+1  current entry count, 0..DEPTH.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- irq_thresh  out  1  level ≥ THRESH.

## Operation

- Storage: DEPTH × 9-bit array {~RxStopBit, RxData}; write pointer `wp` and read pointer `rp`, each ADDR_W bits, wrapping modulo DEPTH; separate `count` register of ADDR_W+1 bits.
- Edge detect: `done_q` registers RxDone. `push = RxDone & ~done_q`. A level held high for many cycles produces exactly one push.
- Pop: `pop = rd_en & ~empty`. rd_en while empty is ignored; there are no state changes and no error.
- Push while not full: write mem[wp], wp+1, count+1.
- Push while full with no pop: the frame is dropped, the array is unchanged, and overrun is set to 1.
- Push and pop in the same cycle, any non-empty level including full: both execute, count is unchanged, and no overrun occurs.
- Pop alone: rp+1, count−1.
- flush: wp=rp=0, count=0. It has priority over push/pop in the same cycle, and a coincident push is discarded. Overrun is not affected by flush. done_q still updates.
- overrun: set by a dropped push, cleared by ovr_clr. If both occur in the same cycle, set wins.
- Outputs are decoded combinationally from registers:
  - empty = (count==0)
  - full = (count==DEPTH)
  - level = count
  - irq_thresh = (count ≥ THRESH)
  - {rd_ferr, rd_data} = mem[rp]
- Memory contents are not reset. rd_data/rd_ferr are don't-care while empty=1.

## Timing

- Reset values: wp=rp=0, count=0, done_q=0, overrun=0. Hence empty=1, full=0, level=0, irq_thresh=0, and rd_data/rd_ferr are undefined.
- Push latency: RxDone rises before pClk edge N. At edge N the entry is written, and empty=0 and level=1 are visible after edge N (one cycle).
- Pop: rd_en sampled high at edge N. The next entry (or empty=1) is visible after edge N. rd_data is valid in the same cycle rd_en is asserted (first-word-fall-through).
- The register block may pop every cycle. Push rate is bounded by the receiver, but the FIFO must accept one push per cycle anyway.
- RxDone already high at reset release: done_q=0, so a push occurs on the first edge. This is accepted behaviour.
- Reset mid-operation: all pointers and flags clear immediately (asynchronously), and pending content is lost.

## Test plan

- Reset, then 3 RxDone pulses with 0x41, 0x42, 0x43 (stop=1) → level 1,2,3; empty=0; rd_data=0x41, rd_ferr=0; three rd_en pops return 0x41, 0x42, 0x43; empty=1 and level=0 afterward.
- RxDone held high 20 cycles with 0x55 → exactly one entry (level=1).
- Push 0xA5 with RxStopBit=0 → rd_ferr=1, rd_data=0xA5.
- 17 pushes 0x00..0x10 with DEPTH=16 → full=1 after the 16th; the 17th is dropped and overrun=1. Pops return 0x00..0x0F. ovr_clr → overrun=0.
- FIFO full, push 0x77 and rd_en in the same cycle → level stays 16, overrun=0. The 16th pop returns 0x77. Also run 40 push/pop cycles to exercise pointer wrap, with data order preserved.
- Level 8 (THRESH=8) → irq_thresh=1; one pop → 0. flush coincident with a push → level=0, empty=1; rd_en while empty → no change.
